// File: rtl/seven_seg_value_encoder_if.sv
// Request/result bundle between the GPIO register block and the value encoder.
interface seven_seg_value_encoder_if;
    logic        valueValid;
    logic [9:0]  value;
    logic [2:0]  decimalPoints;
    logic        blankLeadingZeros;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [23:0] threeDigits;

    modport master (
        output valueValid, value, decimalPoints, blankLeadingZeros,
        input  busy, done, overflow, threeDigits
    );

    modport slave (
        input  valueValid, value, decimalPoints, blankLeadingZeros,
        output busy, done, overflow, threeDigits
    );
endinterface

// File: rtl/seven_seg_value_encoder.sv
// Binary-to-3-digit seven-segment encoder: serial double-dabble, then segment
// encode with leading-zero blanking and dash display for values above 999.
module seven_seg_value_encoder (
    input  logic                      clock,
    input  logic                      reset,
    seven_seg_value_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  bin_q, bin_d;
    logic [2:0]  dp_q;
    logic        blank_q;
    logic        ovf_flag_q;
    logic        pend_vld_q;
    logic [9:0]  pend_value_q;
    logic [2:0]  pend_dp_q;
    logic        pend_blank_q;
    logic [23:0] digits_q, digits_d;
    logic        overflow_q;
    logic        done_q;

    logic        busy;
    logic [9:0]  ld_value;
    logic [2:0]  ld_dp;
    logic        ld_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign busy = (state_q != IDLE);

    // Live input has priority over the pending slot when both are present.
    always_comb begin
        ld_value = pend_value_q;
        ld_dp    = pend_dp_q;
        ld_blank = pend_blank_q;
        if (bus.valueValid) begin
            ld_value = bus.value;
            ld_dp    = bus.decimalPoints;
            ld_blank = bus.blankLeadingZeros;
        end
    end

    // One double-dabble step: add-3 on nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        logic [11:0] adj;
        logic [21:0] shifted;
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj[10:0], bin_q, 1'b0};
        bcd_d   = shifted[21:10];
        bin_d   = shifted[9:0];
    end

    always_comb begin
        logic [3:0] h, t, u;
        h = bcd_q[11:8];
        t = bcd_q[7:4];
        u = bcd_q[3:0];
        digits_d = {dp_q[2], seg7(h), dp_q[1], seg7(t), dp_q[0], seg7(u)};
        if (blank_q && h == 4'd0)
            digits_d[22:16] = 7'h00;
        if (blank_q && h == 4'd0 && t == 4'd0)
            digits_d[14:8] = 7'h00;
        if (ovf_flag_q)
            digits_d = 24'h404040;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bcd_q        <= '0;
            bin_q        <= '0;
            dp_q         <= '0;
            blank_q      <= 1'b0;
            ovf_flag_q   <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= 1'b0;
            digits_q     <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy && bus.valueValid) begin
                pend_vld_q   <= 1'b1;
                pend_value_q <= bus.value;
                pend_dp_q    <= bus.decimalPoints;
                pend_blank_q <= bus.blankLeadingZeros;
            end
            case (state_q)
                IDLE: begin
                    if (bus.valueValid || pend_vld_q) begin
                        bin_q      <= ld_value;
                        bcd_q      <= '0;
                        dp_q       <= ld_dp;
                        blank_q    <= ld_blank;
                        ovf_flag_q <= (ld_value > 10'd999);
                        pend_vld_q <= 1'b0;
                        cnt_q      <= 4'd9;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    if (cnt_q == 4'd0) begin
                        state_q <= ENCODE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ENCODE: begin
                    digits_q   <= digits_d;
                    overflow_q <= ovf_flag_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
    assign bus.threeDigits = digits_q;
endmodule

// File: tb/tb_seven_seg_value_encoder.sv
// Directed-vector bench for seven_seg_value_encoder.
module tb_seven_seg_value_encoder;
    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    seven_seg_value_encoder_if ifc ();

    seven_seg_value_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vv, input logic [9:0] v, input logic [2:0] dp, input logic bl);
        ifc.valueValid        = vv;
        ifc.value             = v;
        ifc.decimalPoints     = dp;
        ifc.blankLeadingZeros = bl;
    endtask

    // Issue one request, then check latency, busy length, single done pulse and result.
    task automatic convert(input string tag, input logic [9:0] v, input logic [2:0] dp,
                           input logic bl, input logic [23:0] exp_dig, input logic exp_ovf);
        int n, busy_n;
        bit seen;
        @(negedge clock);
        drive(1'b1, v, dp, bl);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 10'd0, 3'd0, 1'b0);
        n = 0; busy_n = 0; seen = 0;
        while (!seen && n < 40) begin
            if (ifc.busy) busy_n++;
            @(posedge clock);
            @(negedge clock);
            n++;
            if (ifc.done) seen = 1;
        end
        chk({tag, "_latency"}, n, 11);
        chk({tag, "_busy_cycles"}, busy_n, 11);
        chk({tag, "_busy_low"}, ifc.busy, 1'b0);
        chk({tag, "_digits"}, ifc.threeDigits, exp_dig);
        chk({tag, "_ovf"}, ifc.overflow, exp_ovf);
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_done_single"}, ifc.done, 1'b0);
        chk({tag, "_hold"}, ifc.threeDigits, exp_dig);
    endtask

    initial begin
        int done_n, first_e, second_e;
        logic [23:0] first_d, second_d;
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        drive(1'b0, 10'd0, 3'd0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1'($urandom), 10'($urandom), 3'($urandom), 1'($urandom));
        end
        chk("rst_digits", ifc.threeDigits, 24'h0);
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_done", ifc.done, 1'b0);
        chk("rst_ovf", ifc.overflow, 1'b0);
        drive(1'b0, 10'd0, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_digits", ifc.threeDigits, 24'h0);
        chk("idle_busy", ifc.busy, 1'b0);
        chk("idle_done", ifc.done, 1'b0);

        convert("v123",    10'd123,  3'b000, 1'b0, 24'h065B4F, 1'b0);
        convert("v7_blk",  10'd7,    3'b001, 1'b1, 24'h000087, 1'b0);
        convert("v7_dp",   10'd7,    3'b100, 1'b0, 24'hBF3F07, 1'b0);
        convert("v7_dpall",10'd7,    3'b111, 1'b1, 24'h808087, 1'b0);
        convert("v50_blk", 10'd50,   3'b000, 1'b1, 24'h006D3F, 1'b0);
        convert("v305_blk",10'd305,  3'b000, 1'b1, 24'h4F3F6D, 1'b0);
        convert("v0_blk",  10'd0,    3'b000, 1'b1, 24'h00003F, 1'b0);
        convert("v1000",   10'd1000, 3'b111, 1'b0, 24'h404040, 1'b1);
        convert("v999",    10'd999,  3'b000, 1'b0, 24'h6F6F6F, 1'b0);
        convert("v1023",   10'd1023, 3'b000, 1'b1, 24'h404040, 1'b1);

        // Pending slot: 42 at E0, 500 at E3, 501 at E5; latest pending wins
        @(negedge clock);
        drive(1'b1, 10'd42, 3'b000, 1'b0);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 10'd0, 3'd0, 1'b0);
        done_n = 0; first_e = 0; second_e = 0; first_d = '0; second_d = '0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3) drive(1'b1, 10'd500, 3'b000, 1'b0);
            else if (e == 5) drive(1'b1, 10'd501, 3'b000, 1'b0);
            else drive(1'b0, 10'd0, 3'd0, 1'b0);
            @(posedge clock);
            @(negedge clock);
            if (ifc.done) begin
                done_n++;
                if (done_n == 1) begin first_e = e; first_d = ifc.threeDigits; end
                if (done_n == 2) begin second_e = e; second_d = ifc.threeDigits; end
            end
        end
        drive(1'b0, 10'd0, 3'd0, 1'b0);
        chk("pend_done_count", done_n, 2);
        chk("pend_first_edge", first_e, 11);
        chk("pend_first_digits", first_d, 24'h3F665B);
        chk("pend_second_edge", second_e, 23);
        chk("pend_second_digits", second_d, 24'h6D3F06);

        // Reset in the middle of converting 456
        @(negedge clock);
        drive(1'b1, 10'd456, 3'b000, 1'b0);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 10'd0, 3'd0, 1'b0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_digits", ifc.threeDigits, 24'h0);
        chk("midrst_busy", ifc.busy, 1'b0);
        chk("midrst_done", ifc.done, 1'b0);
        done_n = 0;
        repeat (2) begin
            @(negedge clock);
            if (ifc.done) done_n++;
        end
        reset = 1'b1;
        repeat (14) begin
            @(negedge clock);
            if (ifc.done || ifc.busy) done_n++;
        end
        chk("midrst_no_done", done_n, 0);
        convert("v89_after_rst", 10'd89, 3'b000, 1'b0, 24'h3F7F6F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seven_seg_value_encoder.md
# seven_seg_value_encoder

Converts a 10-bit binary value into three active-high seven-segment patterns packed as the 24-bit `threeDigits` word consumed by the seven-segment scanning driver. It sits directly upstream of that driver in the GPIO module, fed by the GPIO register interface. Conversion is an iterative double-dabble (one shift per cycle), followed by segment encoding, leading-zero blanking and out-of-range indication. A one-deep pending slot absorbs a request that arrives during a conversion.

## Interface
- No parameters.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `valueValid` in 1: load request, sampled every rising edge.
- `value` in 10: binary value to display, 0..999 valid.
- `decimalPoints` in 3: dp enables [2]=hundreds, [1]=tens, [0]=units; latched with `value`.
- `blankLeadingZeros` in 1: leading-zero suppression enable; latched with `value`.
- `busy` out 1: conversion in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse when `threeDigits` updates.
- `overflow` out 1: last displayed value was > 999.
- `threeDigits` out 24: [23:16] hundreds, [15:8] tens, [7:0] units. Per byte: bit0=a … bit6=g, bit7=dp; 1 = segment lit. The scanner inverts for the pins.

## Operation
- **FSM states:**
  - IDLE → CONVERT on an accepted request.
  - CONVERT (10 cycles, 4-bit iteration counter 9→0) → ENCODE.
  - ENCODE (1 cycle) → IDLE.
- **Request acceptance:**
  - In IDLE, `valueValid`=1 loads the shift register with `value`, `decimalPoints`, `blankLeadingZeros`.
  - Range check at acceptance: overflow flag = (`value` > 999).
- **Double-dabble:**
  - 12-bit BCD accumulator plus 10-bit shift register.
  - Each CONVERT cycle, add 3 to every BCD nibble ≥ 5, then shift the whole {BCD, bin} left by 1.
  - After 10 shifts, the BCD nibbles hold hundreds/tens/units. Carry out of bit 11 is discarded; it only occurs for values ≥ 1000, which are flagged.
- **Segment code:**
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Dash = 0x40. Blank = 0x00.
- **ENCODE:**
  - If the overflow flag is set, all three bytes = dash (0x40) and dp bits are ignored.
  - Else if blanking is enabled: hundreds = 0 → hundreds byte blank; hundreds = 0 and tens = 0 → tens byte blank. The units byte is never blanked.
  - dp bit of each byte = latched `decimalPoints` bit. A blanked digit still shows its dp if enabled.
- **Pending slot:**
  - `valueValid`=1 while `busy`=1 stores value/dp/blank into the pending slot and sets pendingValid. A later request overwrites it (latest wins).
  - In IDLE, pendingValid acts as a request and clears on acceptance.
  - If `valueValid`=1 and pendingValid=1 in the same IDLE cycle, the live input wins and pending is discarded.
- **Holding:** `threeDigits` and `overflow` hold their last value between conversions.

## Timing
- **Reset values (async, immediate):**
  - `threeDigits`=0x000000, `busy`=0, `done`=0, `overflow`=0.
  - pendingValid=0, state IDLE, counters 0.
- **Latency:** request accepted at edge E0 → `busy`=1 after E0. CONVERT occupies E1..E10. At E11, `threeDigits`/`overflow` update, `done`=1 for exactly the cycle after E11, and `busy`=0 after E11. Total: 11 cycles.
- **Back-to-back throughput:**
  - A pending request is accepted at E12, with its result at E23.
  - A request presented on the cycle `busy` falls is accepted at that edge.
- **Request on the last busy edge:** a request arriving on the ENCODE edge (E11) goes to pending.
- **Reset mid-conversion:** aborts the conversion, clears everything, and produces no `done`. The next request after reset release behaves normally.
- `done` never asserts twice in consecutive cycles.

## Test plan
- Reset: hold `reset`=0 with random inputs → `threeDigits`=0x000000, `busy`=`done`=`overflow`=0; release, no request → outputs stay 0.
- `value`=123, blank=0, dp=3'b000, one-cycle `valueValid` → `busy` high for 11 cycles, `done` pulse, `threeDigits`=0x065B4F, `overflow`=0.
- `value`=7:
  - blank=1, dp=3'b001 → `threeDigits`=0x000087.
  - blank=0, dp=3'b100 → `threeDigits`=0xBF3F07.
- `value`=1000 → `threeDigits`=0x404040, `overflow`=1; then `value`=999 → `threeDigits`=0x6F6F6F, `overflow`=0.
- Request 42 at E0; requests 500 at E3 and 501 at E5 → first `done` shows 0x3F665B, second `done` 12 cycles later shows 0x6D3F06; 500 never appears.
- `value`=456 accepted, `reset`=0 at E5 for 2 cycles → outputs 0 immediately, no `done`; request 89 after release → `done` after 11 cycles, `threeDigits`=0x3F7F6F.
